// File: rtl/seq_checker.sv
// Locks to the period-7 serial pattern 1,1,0,1,0,0,0, predicts each following bit and
// reports lock status and bit errors. Define SEQCHK_ERRCLR_EN to add the err_clr input.
module seq_checker #(
  parameter int unsigned LOCK_CNT = 7,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERRW     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            seq_in,
`ifdef SEQCHK_ERRCLR_EN
  input  logic            err_clr,
`endif
  output logic            locked,
  output logic            lock_lost,
  output logic            bit_err,
  output logic [ERRW-1:0] err_cnt,
  output logic [2:0]      phase
);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  // Pattern bit for phase i sits at bit i; bit 7 pads the unused phase code.
  localparam logic [7:0] Pattern = 8'b0000_1011;
  localparam logic [3:0] LockCnt = 4'(LOCK_CNT);
  localparam logic [2:0] LossCnt = 3'(LOSS_CNT);

  state_e          state_q, state_d;
  logic [1:0]      hist_q, hist_d;
  logic [1:0]      fill_q, fill_d;
  logic [3:0]      good_q, good_d;
  logic [2:0]      miss_q, miss_d;
  logic [2:0]      phase_q, phase_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            locked_q, locked_d;
  logic            lost_q, lost_d;
  logic            bit_err_q, bit_err_d;

  logic [2:0]      win;
  logic            win_ok;
  logic [2:0]      win_phase;
  logic [1:0]      fill_nxt;
  logic [2:0]      phase_inc;
  logic            match;
  logic [3:0]      good_inc;
  logic [2:0]      miss_inc;
  logic [ERRW-1:0] err_inc;

  // Three consecutive bits (oldest first) identify the phase of the following bit.
  always_comb begin
    win       = {hist_q, seq_in};
    win_ok    = 1'b1;
    win_phase = 3'd0;
    case (win)
      3'b110:  win_phase = 3'd3;
      3'b101:  win_phase = 3'd4;
      3'b010:  win_phase = 3'd5;
      3'b100:  win_phase = 3'd6;
      3'b000:  win_phase = 3'd0;
      3'b001:  win_phase = 3'd1;
      3'b011:  win_phase = 3'd2;
      default: win_ok    = 1'b0;
    endcase
  end

  always_comb begin
    fill_nxt  = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
    phase_inc = (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
    match     = (seq_in == Pattern[phase_q]);
    good_inc  = good_q + 4'd1;
    miss_inc  = miss_q + 3'd1;
    err_inc   = (err_q == '1) ? err_q : err_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    good_d    = good_q;
    miss_d    = miss_q;
    phase_d   = phase_q;
    err_d     = err_q;
    locked_d  = locked_q;
    lost_d    = 1'b0;
    bit_err_d = 1'b0;

    if (en) begin
      hist_d = {hist_q[0], seq_in};
      fill_d = fill_nxt;
      case (state_q)
        StSearch: begin
          if (fill_nxt == 2'd3 && win_ok) begin
            phase_d = win_phase;
            good_d  = 4'd0;
            state_d = StVerify;
          end
        end
        StVerify: begin
          if (match) begin
            good_d  = good_inc;
            phase_d = phase_inc;
            if (good_inc == LockCnt) begin
              state_d  = StLocked;
              locked_d = 1'b1;
              miss_d   = 3'd0;
            end
          end else begin
            // fill stays saturated, so the next enabled edge re-evaluates the window.
            state_d = StSearch;
          end
        end
        StLocked: begin
          phase_d = phase_inc;
          if (match) begin
            miss_d = 3'd0;
          end else begin
            bit_err_d = 1'b1;
            err_d     = err_inc;
            miss_d    = miss_inc;
            if (miss_inc == LossCnt) begin
              state_d  = StSearch;
              locked_d = 1'b0;
              lost_d   = 1'b1;
              miss_d   = 3'd0;
            end
          end
        end
        default: begin
          state_d  = StSearch;
          locked_d = 1'b0;
        end
      endcase
    end

`ifdef SEQCHK_ERRCLR_EN
    // Clear beats a simultaneous error and ignores en.
    if (err_clr) err_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StSearch;
      hist_q    <= 2'd0;
      fill_q    <= 2'd0;
      good_q    <= 4'd0;
      miss_q    <= 3'd0;
      phase_q   <= 3'd0;
      err_q     <= '0;
      locked_q  <= 1'b0;
      lost_q    <= 1'b0;
      bit_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      phase_q   <= phase_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      lost_q    <= lost_d;
      bit_err_q <= bit_err_d;
    end
  end

  assign locked    = locked_q;
  assign lock_lost = lost_q;
  assign bit_err   = bit_err_q;
  assign err_cnt   = err_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: directed scenarios plus a randomized error/enable stream, checked
// against a pattern-level reference model. A second instance with ERRW=2 checks saturation.
module tb_seq_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        seq_in = 1'b0;
  logic        err_clr = 1'b0;
  logic        locked, lock_lost, bit_err;
  logic [15:0] err_cnt;
  logic [2:0]  phase;
  logic        s_locked, s_lock_lost, s_bit_err;
  logic [1:0]  s_err_cnt;
  logic [2:0]  s_phase;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_checker u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .seq_in    (seq_in),
`ifdef SEQCHK_ERRCLR_EN
    .err_clr   (err_clr),
`endif
    .locked    (locked),
    .lock_lost (lock_lost),
    .bit_err   (bit_err),
    .err_cnt   (err_cnt),
    .phase     (phase)
  );

  seq_checker #(.ERRW(2)) u_dut_small (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .seq_in    (seq_in),
`ifdef SEQCHK_ERRCLR_EN
    .err_clr   (err_clr),
`endif
    .locked    (s_locked),
    .lock_lost (s_lock_lost),
    .bit_err   (s_bit_err),
    .err_cnt   (s_err_cnt),
    .phase     (s_phase)
  );

  // Reference model: 0 = hunting, 1 = verifying, 2 = locked.
  int unsigned pat [7] = '{1, 1, 0, 1, 0, 0, 0};
  int m_state, m_phase, m_good, m_miss, m_err;
  bit m_lost, m_be;
  int m_hist[$];
  int src;

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_good = 0; m_miss = 0; m_err = 0;
    m_lost = 0; m_be = 0;
    m_hist.delete();
  endtask

  task automatic model_edge(input bit e, input bit b, input bit clr);
    int p_found;
    m_lost = 0;
    m_be   = 0;
    if (e) begin
      if (m_state == 0) begin
        if (m_hist.size() >= 2) begin
          p_found = -1;
          for (int p = 0; p < 7; p++)
            if (pat[p] == m_hist[0] && pat[(p + 1) % 7] == m_hist[1] && pat[(p + 2) % 7] == b)
              p_found = p;
          if (p_found >= 0) begin
            m_phase = (p_found + 3) % 7;
            m_good  = 0;
            m_state = 1;
          end
        end
      end else if (m_state == 1) begin
        if (b == pat[m_phase]) begin
          m_good++;
          m_phase = (m_phase + 1) % 7;
          if (m_good == 7) begin
            m_state = 2;
            m_miss  = 0;
          end
        end else begin
          m_state = 0;
        end
      end else begin
        if (b == pat[m_phase]) begin
          m_miss = 0;
        end else begin
          m_be = 1;
          m_err++;
          m_miss++;
          if (m_miss == 3) begin
            m_state = 0;
            m_lost  = 1;
            m_miss  = 0;
          end
        end
        m_phase = (m_phase + 1) % 7;
      end
      m_hist.push_back(b);
      if (m_hist.size() > 2) void'(m_hist.pop_front());
    end
    if (clr) m_err = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("locked", 32'(locked), 32'(m_state == 2));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("bit_err", 32'(bit_err), 32'(m_be));
    chk("err_cnt", 32'(err_cnt), (m_err > 65535) ? 65535 : m_err);
    chk("small_err_cnt", 32'(s_err_cnt), (m_err > 3) ? 3 : m_err);
    chk("small_locked", 32'(s_locked), 32'(m_state == 2));
    if (m_state != 0) chk("phase", 32'(phase), m_phase);
  endtask

  task automatic step(input bit e, input bit b, input bit clr);
    bit use_clr;
    en      = e;
    seq_in  = b;
    err_clr = clr;
    @(posedge clk);
`ifdef SEQCHK_ERRCLR_EN
    use_clr = clr;
`else
    use_clr = 1'b0;
`endif
    model_edge(e, b, use_clr);
    #1 chk_all();
  endtask

  task automatic send(input bit flip);
    bit b;
    b   = bit'(pat[src]) ^ flip;
    src = (src + 1) % 7;
    step(1'b1, b, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_lock_lost"}, 32'(lock_lost), 0);
    chk({tag, "_bit_err"}, 32'(bit_err), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    chk({tag, "_phase"}, 32'(phase), 0);
  endtask

  initial begin
    int hold_phase, hold_err;
    model_reset();
    src = 0;

    // Reset state
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // 1: clean acquisition from phase 0
    for (int i = 0; i < 3; i++) send(1'b0);
    chk("t1_verify_phase", 32'(phase), 3);
    chk("t1_not_locked", 32'(locked), 0);
    for (int i = 0; i < 6; i++) send(1'b0);
    chk("t1_edge9_unlocked", 32'(locked), 0);
    send(1'b0);
    chk("t1_edge10_locked", 32'(locked), 1);
    chk("t1_err_zero", 32'(err_cnt), 0);

    // 2: single error while locked
    send(1'b1);
    chk("t2_bit_err", 32'(bit_err), 1);
    chk("t2_err_cnt", 32'(err_cnt), 1);
    chk("t2_locked", 32'(locked), 1);
    for (int i = 0; i < 4; i++) send(1'b0);

    // 3: three consecutive errors drop lock, clean stream reacquires
    for (int i = 0; i < 3; i++) send(1'b1);
    chk("t3_lock_lost", 32'(lock_lost), 1);
    chk("t3_unlocked", 32'(locked), 0);
    chk("t3_err_cnt", 32'(err_cnt), 4);
    for (int i = 0; i < 20; i++) send(1'b0);
    chk("t3_relocked", 32'(locked), 1);

    // 4: en low holds everything
    hold_phase = m_phase;
    hold_err   = m_err;
    for (int i = 0; i < 5; i++) step(1'b0, bit'(i & 1), 1'b0);
    chk("t4_phase_held", 32'(phase), hold_phase);
    chk("t4_err_held", 32'(err_cnt), hold_err);
    chk("t4_locked_held", 32'(locked), 1);

    // 5: asynchronous reset mid-lock, then reacquire
    #2 reset = 1'b0;
    model_reset();
    #1 chk_reset_outputs("t5_async");
    @(negedge clk);
    reset = 1'b1;
    src = 0;
    for (int i = 0; i < 10; i++) send(1'b0);
    chk("t5_relocked", 32'(locked), 1);

    // 6: saturation of the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      send(1'b1);
      for (int i = 0; i < 3; i++) send(1'b0);
    end
    chk("t6_small_sat", 32'(s_err_cnt), 3);
    chk("t6_wide_cnt", 32'(err_cnt), 5);
`ifdef SEQCHK_ERRCLR_EN
    step(1'b0, 1'b0, 1'b1);
    chk("t6_clr_wide", 32'(err_cnt), 0);
    chk("t6_clr_small", 32'(s_err_cnt), 0);
    err_clr = 1'b0;
`endif

    // Randomized enables, isolated errors and error bursts
    for (int i = 0; i < 600; i++) begin
      bit e, clr;
      int r;
      e   = ($urandom_range(7) != 0);
      clr = ($urandom_range(63) == 0);
      r   = $urandom_range(31);
      if (!e) begin
        step(1'b0, bit'($urandom_range(1)), clr);
      end else if (r == 0) begin
        for (int j = 0; j < 3; j++) send(1'b1);
      end else begin
        bit b;
        b   = bit'(pat[src]) ^ (r == 1);
        src = (src + 1) % 7;
        step(1'b1, b, clr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
